dsp_pool_arbiter: RTL
=====================

# dsp_pool_arbiter

Shares one pool of N_DSP multiplier slices between N_REQ compute engines. Requesters include the matrix multiplier and future vector/activation units. Arbitration is round-robin with burst ownership, a bounded hold time and a lock override. The block registers the winning requester's operand and clock-enable buses onto the slice inputs and returns each slice product to its issuing requester with a per-requester valid. It sits between the engines and the DSP primitive wrapper.

## Interface
- N_REQ, 4, number of requesters (2..8)
- N_DSP, 5, number of shared slices
- OP_W, 18, operand width per slice port
- P_W, 37, product width per slice
- DSP_LAT, 1, slice latency in cycles, from registered operand to dsp_out (1..4)
- MAX_HOLD, 64, cycles an unlocked owner may hold the pool while others wait
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  N_REQ  requester i wants the pool; level, held for the whole burst
- lock  in  N_REQ  owner i refuses preemption while high
- req_ce  in  N_REQ  requester i issues a valid operand set this cycle
- req_a, req_b  in  N_REQ×N_DSP×OP_W  operand sets per requester
- gnt  out  N_REQ  one-hot-or-zero, registered ownership
- dsp_a0, dsp_b0  out  N_DSP×OP_W  registered slice operands
- dsp_ce  out  1  registered slice enable
- dsp_out  in  N_DSP×P_W  slice products
- rsp_data  out  N_DSP×P_W  combinational copy of dsp_out, broadcast to all requesters
- rsp_valid  out  N_REQ  rsp_data belongs to requester i this cycle
- preempted  out  1  one-cycle pulse when an owner loses the pool to MAX_HOLD

## Operation
- States: IDLE, OWN, HANDOFF.
- IDLE:
  - No gnt; dsp_ce=0.
  - When any req is high, pick the winner by round-robin starting at rr_ptr. Set gnt for the winner and go to OWN.
- OWN:
  - Each cycle, dsp_a0/dsp_b0 <= owner's req_a/req_b and dsp_ce <= req_ce[owner].
  - hold_cnt increments and saturates at MAX_HOLD.
  - Go to HANDOFF when req[owner]=0.
  - Also go to HANDOFF (and pulse preempted) when hold_cnt==MAX_HOLD, lock[owner]=0, and any other req is high.
  - Leaving OWN: rr_ptr <= owner+1 (wraps modulo N_REQ), gnt <= 0.
- HANDOFF:
  - Exactly one cycle: gnt=0, dsp_ce=0, dsp_a0/dsp_b0 <= 0.
  - Then run the IDLE arbitration directly. Go to OWN with the new winner, or to IDLE if no req.
- Result routing:
  - A tag pipeline of DSP_LAT+1 stages carries {valid=req_ce[owner] & gnt[owner], id=owner}.
  - rsp_valid[id] is high when the tag at the last stage is valid.
  - In-flight results from the previous owner drain correctly after handoff.
- req_ce from a non-owner is ignored and never reaches the slices.
- A requester dropping req in the same cycle it is granted still receives the one-cycle grant, then HANDOFF follows.

## Timing
- Reset values:
  - gnt=0, dsp_a0=0, dsp_b0=0, dsp_ce=0.
  - rsp_valid=0, preempted=0.
  - rr_ptr=0, hold_cnt=0, tag pipeline cleared, state IDLE.
- Grant latency: req high at cycle t in IDLE gives gnt at t+1.
- Issue-to-response:
  - Owner drives req_ce=1 at cycle t with gnt high.
  - Slice sees the operands at t+1.
  - rsp_valid at t+1+DSP_LAT.
- Switch cost: minimum 1 dead cycle (HANDOFF) between owners. Back-to-back bursts of the same requester also pass through HANDOFF.
- Reset mid-burst:
  - All outputs return to their reset values immediately.
  - In-flight tags are discarded; no rsp_valid for them.
- Simultaneous requests: the first requester at or after rr_ptr wins. With rr_ptr=0 after reset, requester 0 wins.

## Structure
- Shared npu_pkg:
  - OP_W, P_W, N_DSP defaults.
  - dsp_operand_t and dsp_product_t typedefs.
  - arb_state_e enum {IDLE, OWN, HANDOFF}.
- One sub-module: rr_pick, a combinational round-robin priority picker (req vector + pointer → one-hot + index). It is reused by other arbiters.
- Tag pipeline and operand mux stay inline.

## Test plan
- Single requester:
  - req[1]=1 at cycle 2, ce every cycle, a=3, b=5 on all slices.
  - Required: gnt[1] at cycle 3. With DSP_LAT=1, rsp_valid[1] at cycle 5 with rsp_data=15 on all slices.
- Contention: req=4'b1011 from reset.
  - Required: grant order 0, 1, 3, 0 as each drops req after 8 cycles.
  - Exactly 1 HANDOFF cycle (gnt=0, dsp_ce=0) between owners.
- Preemption, MAX_HOLD=16:
  - Requester 2 holds with lock=0 while req[0] is high.
  - Required: preempted pulses after 16 owned cycles; gnt[0] two cycles later.
  - Repeat with lock[2]=1: no preemption.
- Drain across handoff, DSP_LAT=3:
  - Owner 0 issues in its last owned cycle.
  - Required: rsp_valid[0] 4 cycles later, while gnt[1] is already high; no rsp_valid[1] for that product.
- Non-owner ce: req_ce[2]=1 with gnt[2]=0 → dsp_ce stays 0 and rsp_valid[2] stays 0.
- Reset mid-burst:
  - Assert rst_n=0 with two results in flight.
  - Required: all outputs 0 immediately; no rsp_valid after release; first grant goes to requester 0.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU types and default widths for the DSP slice pool and its clients.
// No logic here: typedefs, default sizes and a small index helper only.
// Used by every block that talks to the shared multiplier slices.
package npu_pkg;

  // Default slice geometry; blocks may override through their own parameters.
  localparam int OP_W  = 18;
  localparam int P_W   = 37;
  localparam int N_DSP = 5;

  typedef logic [OP_W-1:0] dsp_operand_t;
  typedef logic [P_W-1:0]  dsp_product_t;

  // Pool ownership phases: nobody owns, someone owns, one dead cycle between owners.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    HANDOFF = 2'd2
  } arb_state_e;

  // Increment an index and wrap it at n (n need not be a power of two).
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/dsp_pool_arbiter_rr_pick.sv
// Round-robin priority picker: first set request at or after the pointer wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to act on the pick.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;

  // Walk the request vector starting at the pointer, wrapping modulo N; keep the first hit.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr_i) + i) % N);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsp_pool_arbiter.sv
// Shares one pool of multiplier slices between engines with round-robin burst ownership.
// Latency: grant 1 cycle after req; operands registered 1 cycle; response DSP_LAT after that.
// Backpressure: non-owners are ignored; an unlocked owner is preempted after MAX_HOLD cycles.
module dsp_pool_arbiter #(
  parameter int N_REQ    = 4,
  parameter int N_DSP    = npu_pkg::N_DSP,
  parameter int OP_W     = npu_pkg::OP_W,
  parameter int P_W      = npu_pkg::P_W,
  parameter int DSP_LAT  = 1,
  parameter int MAX_HOLD = 64
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [N_REQ-1:0]                        req_i,
  input  logic [N_REQ-1:0]                        lock_i,
  input  logic [N_REQ-1:0]                        req_ce_i,
  input  logic [N_REQ-1:0][N_DSP-1:0][OP_W-1:0]   req_a_i,
  input  logic [N_REQ-1:0][N_DSP-1:0][OP_W-1:0]   req_b_i,
  output logic [N_REQ-1:0]                        gnt_o,
  output logic [N_DSP-1:0][OP_W-1:0]              dsp_a0_o,
  output logic [N_DSP-1:0][OP_W-1:0]              dsp_b0_o,
  output logic                                    dsp_ce_o,
  input  logic [N_DSP-1:0][P_W-1:0]               dsp_out_i,
  output logic [N_DSP-1:0][P_W-1:0]               rsp_data_o,
  output logic [N_REQ-1:0]                        rsp_valid_o,
  output logic                                    preempted_o
);

  import npu_pkg::*;

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW  = $clog2(MAX_HOLD + 1);

  // Ownership state
  arb_state_e                  state_q, state_d;
  logic [N_REQ-1:0]            gnt_q, gnt_d;
  logic [IDW-1:0]              owner_q, owner_d;
  logic [IDW-1:0]              rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]               hold_q, hold_d;

  // Registered slice inputs
  logic [N_DSP-1:0][OP_W-1:0]  dsp_a_q, dsp_a_d;
  logic [N_DSP-1:0][OP_W-1:0]  dsp_b_q, dsp_b_d;
  logic                        dsp_ce_q, dsp_ce_d;

  // Result tags: one stage per cycle between issue and product arrival
  logic [DSP_LAT:0]            tag_vld_q;
  logic [DSP_LAT:0][IDW-1:0]   tag_id_q;

  // Picker and owner-derived conditions
  logic [N_REQ-1:0]            pick_gnt;
  logic [IDW-1:0]              pick_idx;
  logic                        pick_any;
  logic [IDW-1:0]              owner_nxt;
  logic                        owner_req;
  logic                        owner_lock;
  logic                        others_req;
  logic                        hold_full;
  logic                        preempt_cond;
  logic                        leave_own;
  logic                        issue;

  rr_pick #(
    .N  (N_REQ),
    .IW (IDW)
  ) u_rr_pick (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // gnt_q is one-hot on owner_q exactly while in OWN, so it doubles as the ownership qualifier.
  assign owner_nxt    = IDW'(wrap_inc(int'(owner_q), N_REQ));
  assign owner_req    = req_i[owner_q];
  assign owner_lock   = lock_i[owner_q];
  assign others_req   = |(req_i & ~gnt_q);
  assign hold_full    = (hold_q == HW'(MAX_HOLD));
  // An owner that is already letting go this cycle is not counted as preempted.
  assign preempt_cond = owner_req && hold_full && !owner_lock && others_req;
  assign leave_own    = (state_q == OWN) && (!owner_req || preempt_cond);
  assign issue        = gnt_q[owner_q] & req_ce_i[owner_q];

  // State register: ownership, pointer, hold counter and registered slice inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      hold_q   <= '0;
      dsp_a_q  <= '0;
      dsp_b_q  <= '0;
      dsp_ce_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
      dsp_a_q  <= dsp_a_d;
      dsp_b_q  <= dsp_b_d;
      dsp_ce_q <= dsp_ce_d;
    end
  end

  // Next-state: arbitrate from IDLE/HANDOFF, hold or release ownership in OWN.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    case (state_q)
      IDLE, HANDOFF: begin
        // The dead handoff cycle arbitrates exactly like IDLE, with the advanced pointer.
        if (pick_any) begin
          state_d = OWN;
          gnt_d   = pick_gnt;
          owner_d = pick_idx;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      OWN: begin
        if (!hold_full) begin
          hold_d = hold_q + 1'b1;
        end
        if (leave_own) begin
          state_d  = HANDOFF;
          gnt_d    = '0;
          rr_ptr_d = owner_nxt;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Outputs: the owner's operands reach the slices only while in OWN; preemption pulse.
  always_comb begin
    dsp_a_d     = '0;
    dsp_b_d     = '0;
    dsp_ce_d    = 1'b0;
    preempted_o = 1'b0;
    if (state_q == OWN) begin
      dsp_a_d     = req_a_i[owner_q];
      dsp_b_d     = req_b_i[owner_q];
      dsp_ce_d    = req_ce_i[owner_q];
      preempted_o = preempt_cond;
    end
  end

  // Tag pipeline: remembers who issued each operand set so late products find their owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      tag_vld_q[0] <= issue;
      tag_id_q[0]  <= owner_q;
      for (int k = 1; k <= DSP_LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
    end
  end

  // Response steering: decode the oldest tag into a per-requester valid.
  always_comb begin
    rsp_valid_o = '0;
    if (tag_vld_q[DSP_LAT]) begin
      rsp_valid_o[tag_id_q[DSP_LAT]] = 1'b1;
    end
  end

  assign rsp_data_o = dsp_out_i;
  assign gnt_o      = gnt_q;
  assign dsp_a0_o   = dsp_a_q;
  assign dsp_b0_o   = dsp_b_q;
  assign dsp_ce_o   = dsp_ce_q;

endmodule
